// File: rtl/div_share_pkg.sv
// div_share_pkg: divider widths/latency and the per-operation tag; DIV_SHARE_ZERO_FLAG_EN adds a divide-by-zero bit to the tag
package div_share_pkg;
  localparam int DIV_A_W = 48;
  localparam int DIV_B_W = 24;
  localparam int DIV_R_W = 23;
  localparam int DIV_LAT = 8;
  // id field is sized for the largest supported requester count (8)
  localparam int TAG_ID_W = 3;
  typedef struct packed {
    logic valid;
    logic [TAG_ID_W-1:0] id;
`ifdef DIV_SHARE_ZERO_FLAG_EN
    logic dz;
`endif
  } tag_t;
endpackage

// File: rtl/div_share_if.sv
// div_share_if: requester-side bus of the shared divider; rsp_dz exists only with DIV_SHARE_ZERO_FLAG_EN
interface div_share_if #(parameter int NREQ = 4);
  import div_share_pkg::*;
  logic [NREQ-1:0] req;
  logic [NREQ*DIV_A_W-1:0] req_a;
  logic [NREQ*DIV_B_W-1:0] req_b;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] rsp_vld;
  logic [DIV_A_W-1:0] rsp_q;
  logic [DIV_R_W-1:0] rsp_rem;
  logic busy;
`ifdef DIV_SHARE_ZERO_FLAG_EN
  logic rsp_dz;
  modport master (output req, req_a, req_b, input gnt, rsp_vld, rsp_q, rsp_rem, busy, rsp_dz);
  modport slave (input req, req_a, req_b, output gnt, rsp_vld, rsp_q, rsp_rem, busy, rsp_dz);
`else
  modport master (output req, req_a, req_b, input gnt, rsp_vld, rsp_q, rsp_rem, busy);
  modport slave (input req, req_a, req_b, output gnt, rsp_vld, rsp_q, rsp_rem, busy);
`endif
endinterface

// File: rtl/divi_u48_u24_8.sv
// divi_u48_u24_8: 8-stage pipelined unsigned 48/24 restoring divider, six quotient bits per stage; datapath regs have no reset
module divi_u48_u24_8 (
  input  logic        clk,
  input  logic        en,
  input  logic        vldin,
  input  logic [47:0] ain,
  input  logic [23:0] bin,
  output logic        vldout,
  output logic [47:0] out,
  output logic [22:0] remainder
);
  logic [7:0][24:0] r;
  logic [7:0][47:0] a;
  logic [7:0][23:0] b;
  logic [7:0] v;
  logic unused_rem_hi;
  // shifts six dividend bits into the partial remainder; quotient bits refill a from the bottom
  function automatic logic [72:0] step6(input logic [24:0] ri, input logic [47:0] ai, input logic [23:0] bi);
    logic [24:0] rr;
    logic [47:0] aa;
    rr = ri;
    aa = ai;
    for (int k = 0; k < 6; k++) begin
      rr = {rr[23:0], aa[47]};
      aa = {aa[46:0], 1'b0};
      if (rr >= {1'b0, bi}) begin
        rr = rr - {1'b0, bi};
        aa[0] = 1'b1;
      end
    end
    return {rr, aa};
  endfunction
  // every enabled cycle each stage retires six more quotient bits
  always_ff @(posedge clk)
    if (en) begin
      {r[0], a[0]} <= step6(25'd0, ain, bin);
      b[0] <= bin;
      v[0] <= vldin;
      for (int s = 1; s < 8; s++) begin
        {r[s], a[s]} <= step6(r[s-1], a[s-1], b[s-1]);
        b[s] <= b[s-1];
        v[s] <= v[s-1];
      end
    end
  // with b=0 the remainder register simply accumulates a, so its low bits already equal a[22:0]
  assign vldout = v[7];
  assign out = (b[7] == '0) ? '0 : a[7];
  assign remainder = r[7][22:0];
  assign unused_rem_hi = ^r[7][24:23];
endmodule

// File: rtl/rr_arb_onehot.sv
// rr_arb_onehot: grants the first eligible requester at or after ptr; the caller owns and advances ptr
module rr_arb_onehot #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] elig,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);
  // scan from farthest to nearest so the requester closest to ptr is written last and wins
  always_comb begin
    gnt = '0;
    idx = '0;
    any = |elig;
    for (int k = N - 1; k >= 0; k--)
      if (elig[(int'(ptr) + k) % N]) idx = W'((int'(ptr) + k) % N);
    if (any) gnt[idx] = 1'b1;
  end
endmodule

// File: rtl/div_share_ctrl.sv
// div_share_ctrl: round-robin time-sharing of one pipelined 48/24 divider; DIV_SHARE_ZERO_FLAG_EN adds rsp_dz
module div_share_ctrl import div_share_pkg::*; #(
  parameter int NREQ = 4,
  parameter int IDW = 2,
  parameter int LAT = DIV_LAT,
  parameter int MAXOUT = 3
) (
  input logic clk,
  input logic rst_n,
  input logic hold,
  div_share_if.slave bus
);
  localparam int CW = $clog2(MAXOUT + 2);
  localparam int EW = $clog2(LAT + 1);
  logic en, live, any, vldin, fire, div_vld, ovf;
  logic [IDW-1:0] ptr, win;
  logic [NREQ-1:0] elig, arb_gnt;
  logic [CW-1:0] outst [NREQ];
  logic [EW-1:0] en_cnt;
  tag_t pipe [LAT];
  tag_t head, tail;
  logic [DIV_A_W-1:0] ain, div_q, q_r;
  logic [DIV_B_W-1:0] bin;
  logic [DIV_R_W-1:0] div_rem, rem_r;

  assign en = ~hold;
  assign live = en & rst_n;

  // a requester competes only while it has room for another in-flight operation
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) elig[i] = bus.req[i] && (outst[i] < CW'(MAXOUT));
  end

  rr_arb_onehot #(.N(NREQ), .W(IDW)) u_arb (.elig(elig), .ptr(ptr), .gnt(arb_gnt), .idx(win), .any(any));

  assign bus.gnt = arb_gnt & {NREQ{live}};
  assign vldin = any & live;
  assign ain = bus.req_a[win*DIV_A_W +: DIV_A_W];
  assign bin = bus.req_b[win*DIV_B_W +: DIV_B_W];

  divi_u48_u24_8 u_div (
    .clk(clk), .en(en), .vldin(vldin), .ain(ain), .bin(bin),
    .vldout(div_vld), .out(div_q), .remainder(div_rem)
  );

  // tag entering the pipeline alongside the operands
  always_comb begin
    head = '0;
    head.valid = vldin;
    head.id = TAG_ID_W'(win);
`ifdef DIV_SHARE_ZERO_FLAG_EN
    head.dz = bin == '0;
`endif
  end

  // tag shift register tracks the divider stage by stage; it alone decides which outputs are real
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int k = 0; k < LAT; k++) pipe[k] <= '0;
    else if (en) begin
      pipe[0] <= head;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end

  assign tail = pipe[LAT-1];
  assign fire = tail.valid & en;
  assign bus.rsp_vld = fire ? NREQ'(1) << tail.id : '0;
  assign bus.rsp_q = fire ? div_q : q_r;
  assign bus.rsp_rem = fire ? div_rem : rem_r;

  // results are held between responses
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q_r <= '0;
      rem_r <= '0;
    end else if (fire) begin
      q_r <= div_q;
      rem_r <= div_rem;
    end

`ifdef DIV_SHARE_ZERO_FLAG_EN
  logic dz_r;
  assign bus.rsp_dz = fire ? tail.dz : dz_r;
  // zero flag held alongside the quotient
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) dz_r <= 1'b0;
    else if (fire) dz_r <= tail.dz;
`endif

  // rotate priority past the winner; hold position when nobody is granted
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (vldin) ptr <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;

  // in-flight count per requester; a grant and a response in the same cycle cancel
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < NREQ; i++) outst[i] <= '0;
    else for (int i = 0; i < NREQ; i++)
      if (bus.gnt[i] != bus.rsp_vld[i]) outst[i] <= bus.gnt[i] ? outst[i] + 1'b1 : outst[i] - 1'b1;

  // busy whenever any tag is still travelling
  always_comb begin
    bus.busy = 1'b0;
    for (int k = 0; k < LAT; k++) bus.busy = bus.busy | pipe[k].valid;
  end

  // enabled cycles since reset, saturating once the divider pipeline has fully refilled
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) en_cnt <= '0;
    else if (en && en_cnt != EW'(LAT)) en_cnt <= en_cnt + 1'b1;

  // counter overflow flag, only observed by the assertion below
  always_comb begin
    ovf = 1'b0;
    for (int i = 0; i < NREQ; i++) ovf = ovf | (outst[i] > CW'(MAXOUT));
  end

  assert property (@(posedge clk) disable iff (!rst_n) (fire && en_cnt == EW'(LAT)) |-> div_vld);
  assert property (@(posedge clk) disable iff (!rst_n) !ovf);
endmodule

// File: tb/tb_div_share_ctrl.sv
// tb_div_share_ctrl: directed and randomized bench for div_share_ctrl against a queue-based reference model
module tb_div_share_ctrl;
  localparam int NREQ = 4, LAT = 8, MAXOUT = 3;
  typedef struct {
    int id;
    logic [47:0] q;
    logic [22:0] r;
    logic dz;
    int due;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b1, hold = 1'b0;
  int checks = 0, failures = 0;
  exp_t fl[$];
  logic [47:0] opa [NREQ];
  logic [23:0] opb [NREQ];
  int kk [NREQ];
  logic [NREQ-1:0] want = '0;
  logic hold_v = 1'b0;
  int ptr = 0, ec = 0, mode = 0;
  logic [47:0] lq = '0;
  logic [22:0] lr = '0;
  logic ldz = 1'b0;

  div_share_if #(.NREQ(NREQ)) bus ();
  div_share_ctrl #(.NREQ(NREQ), .IDW(2), .LAT(LAT), .MAXOUT(MAXOUT)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int cnt(input int j);
    int n = 0;
    foreach (fl[x]) if (fl[x].id == j) n++;
    return n;
  endfunction

  function automatic exp_t model(input int w);
    exp_t e;
    e.id = w;
    e.dz = opb[w] == 24'd0;
    e.due = ec + LAT;
    if (e.dz) begin
      e.q = '0;
      e.r = opa[w][22:0];
    end else begin
      e.q = opa[w] / 48'(opb[w]);
      e.r = 23'(opa[w] % 48'(opb[w]));
    end
    return e;
  endfunction

  function automatic void new_ops(input int i);
    if (mode == 1) begin
      opa[i] = 48'(i * 1000 + kk[i]);
      opb[i] = 24'(i + 3);
      kk[i]++;
    end else if (mode == 2) begin
      opa[i] = 48'({$urandom, $urandom});
      opb[i] = ($urandom_range(0, 9) == 0) ? 24'd0 :
               ($urandom_range(0, 1) == 1) ? 24'($urandom) : 24'($urandom_range(1, 300));
    end
  endfunction

  task automatic cyc();
    int w, j;
    logic [NREQ-1:0] eg, ev;
    @(negedge clk);
    if (mode == 2) begin
      hold_v = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < NREQ; i++) if (!want[i] && $urandom_range(0, 1) == 1) want[i] = 1'b1;
    end
    hold = hold_v;
    bus.req = want;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*48 +: 48] = opa[i];
      bus.req_b[i*24 +: 24] = opb[i];
    end
    #1;
    w = -1;
    for (int k = 0; k < NREQ; k++) begin
      j = (ptr + k) % NREQ;
      if (w < 0 && !hold_v && want[j] && cnt(j) < MAXOUT) w = j;
    end
    eg = (w < 0) ? '0 : NREQ'(1) << w;
    chk("gnt", 64'(bus.gnt), 64'(eg));
    chk("busy", 64'(bus.busy), 64'(fl.size() != 0));
    ev = '0;
    if (!hold_v && fl.size() != 0 && fl[0].due == ec) begin
      ev = NREQ'(1) << fl[0].id;
      lq = fl[0].q;
      lr = fl[0].r;
      ldz = fl[0].dz;
      void'(fl.pop_front());
    end
    chk("rsp_vld", 64'(bus.rsp_vld), 64'(ev));
    chk("rsp_q", 64'(bus.rsp_q), 64'(lq));
    chk("rsp_rem", 64'(bus.rsp_rem), 64'(lr));
`ifdef DIV_SHARE_ZERO_FLAG_EN
    chk("rsp_dz", 64'(bus.rsp_dz), 64'(ldz));
`endif
    if (w >= 0) begin
      fl.push_back(model(w));
      ptr = (w + 1) % NREQ;
      if (mode == 0) want[w] = 1'b0;
      else begin
        if (mode == 2) want[w] = 1'($urandom_range(0, 1));
        new_ops(w);
      end
    end
    if (!hold_v) ec++;
  endtask

  task automatic drain();
    want = '0;
    hold_v = 1'b0;
    for (int t = 0; t < 40 && fl.size() != 0; t++) cyc();
    chk("drain_bound", 64'(fl.size()), 64'd0);
  endtask

  initial begin
    bus.req = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      opa[i] = '0;
      opb[i] = 24'd1;
      kk[i] = 0;
    end
    #1 rst_n = 1'b0;
    #2;
    chk("rst_gnt", 64'(bus.gnt), 64'd0);
    chk("rst_vld", 64'(bus.rsp_vld), 64'd0);
    chk("rst_q", 64'(bus.rsp_q), 64'd0);
    chk("rst_rem", 64'(bus.rsp_rem), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    mode = 0;
    opa[0] = 48'd100;
    opb[0] = 24'd7;
    want = 4'b0001;
    for (int t = 0; t < 10; t++) cyc();
    chk("single_q", 64'(bus.rsp_q), 64'd14);
    chk("single_rem", 64'(bus.rsp_rem), 64'd2);

    mode = 1;
    for (int i = 0; i < NREQ; i++) new_ops(i);
    want = '1;
    for (int t = 0; t < 24; t++) cyc();
    drain();

    want = 4'b0100;
    for (int t = 0; t < 20; t++) cyc();
    drain();

    for (int i = 0; i < NREQ; i++) new_ops(i);
    mode = 0;
    want = '1;
    for (int t = 0; t < 4; t++) cyc();
    hold_v = 1'b1;
    for (int t = 0; t < 5; t++) cyc();
    hold_v = 1'b0;
    drain();

    opa[1] = 48'h123456789ABC;
    opb[1] = 24'd0;
    want = 4'b0010;
    cyc();
    drain();
    chk("dz_q", 64'(bus.rsp_q), 64'd0);
    chk("dz_rem", 64'(bus.rsp_rem), 64'h789ABC);
`ifdef DIV_SHARE_ZERO_FLAG_EN
    chk("dz_flag", 64'(bus.rsp_dz), 64'd1);
`endif
    opb[1] = 24'd5;
    want = 4'b0010;
    cyc();
    drain();
`ifdef DIV_SHARE_ZERO_FLAG_EN
    chk("dz_flag_b5", 64'(bus.rsp_dz), 64'd0);
`endif

    mode = 2;
    for (int i = 0; i < NREQ; i++) new_ops(i);
    want = '0;
    for (int t = 0; t < 300; t++) cyc();
    mode = 0;
    hold_v = 1'b0;
    for (int t = 0; t < 40 && want != '0; t++) cyc();
    drain();

    mode = 1;
    for (int i = 0; i < NREQ; i++) new_ops(i);
    want = '1;
    for (int t = 0; t < 6; t++) cyc();
    want = '0;
    mode = 0;
    @(negedge clk);
    bus.req = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 64'(bus.gnt), 64'd0);
    chk("mid_rst_vld", 64'(bus.rsp_vld), 64'd0);
    chk("mid_rst_q", 64'(bus.rsp_q), 64'd0);
    chk("mid_rst_rem", 64'(bus.rsp_rem), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    fl.delete();
    ptr = 0;
    lq = '0;
    lr = '0;
    ldz = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 10; t++) cyc();

    opa[3] = 48'hFFFF_FFFF_FFFF;
    opb[3] = 24'hFFFFFF;
    want = 4'b1000;
    cyc();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
